// File: rtl/dqs_wr_pattern_gen_pkg.sv
// Shared DQS write-path definitions: FSM encoding, nibble patterns
// and the read-window counter width.
package dqs_wr_pattern_gen_pkg;

  localparam int RD_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_B0   = 3'd2,
    ST_B1   = 3'd3,
    ST_POST = 3'd4
  } wr_state_t;

  localparam logic [3:0] DQS_PRE_D    = 4'b0000;
  localparam logic [3:0] DQS_PRE_T    = 4'b0011;
  localparam logic [3:0] DQS_TOGGLE_D = 4'b0101;
  localparam logic [3:0] DQS_POST_T   = 4'b1100;
  localparam logic [3:0] DQS_IDLE_T   = 4'b1111;

  function automatic logic [3:0] dqs_d(wr_state_t s);
    logic [3:0] d;
    d = 4'b0000;
    if (s == ST_PRE) d = DQS_PRE_D;
    if (s == ST_B0 || s == ST_B1) d = DQS_TOGGLE_D;
    return d;
  endfunction

  function automatic logic [3:0] dqs_t(wr_state_t s);
    logic [3:0] t;
    t = DQS_IDLE_T;
    unique case (s)
      ST_PRE:  t = DQS_PRE_T;
      ST_B0:   t = 4'b0000;
      ST_B1:   t = 4'b0000;
      ST_POST: t = DQS_POST_T;
      default: t = DQS_IDLE_T;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/dqs_wr_pattern_gen_dci_window_timer.sv
// Read-termination window: loadable, reloadable down-counter.
// The window is open while the count is nonzero.
module dci_window_timer
  import dqs_wr_pattern_gen_pkg::*;
#(
  parameter int RD_WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic window_open
);

  logic [RD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RD_CNT_W'(RD_WINDOW);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign window_open = (cnt != '0);

endmodule

// File: rtl/dqs_wr_pattern_gen.sv
// DQS preamble/toggle/postamble and DCI control for one byte lane.
// Define DQS_WR_ERR_EN to build the sticky err/err_clr logic.
module dqs_wr_pattern_gen
  import dqs_wr_pattern_gen_pkg::*;
#(
  parameter int RD_WINDOW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       err_clr,
  output logic [3:0] dqs_din,
  output logic [3:0] dqs_tin,
  output logic       dci_disable,
  output logic       busy,
  output logic       err
);

  wr_state_t state, state_nxt;
  logic window_open;
  logic wr_ok, rd_ok, err_set;

  always_comb begin
    wr_ok = wr_req && !window_open &&
            (state == ST_IDLE || state == ST_B1 ||
             state == ST_POST);
    // Both the FSM state and the registered busy flag block reads.
    rd_ok = rd_req && state == ST_IDLE && !busy && !wr_ok;
    err_set = (wr_req && !wr_ok) || (rd_req && !rd_ok);
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (wr_ok) state_nxt = ST_PRE;
      ST_PRE:  state_nxt = ST_B0;
      ST_B0:   state_nxt = ST_B1;
      ST_B1:   state_nxt = wr_ok ? ST_B0 : ST_POST;
      ST_POST: state_nxt = wr_ok ? ST_PRE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  dci_window_timer #(
    .RD_WINDOW(RD_WINDOW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (rd_ok),
    .window_open(window_open)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dqs_din     <= 4'h0;
      dqs_tin     <= DQS_IDLE_T;
      dci_disable <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      dqs_din     <= dqs_d(state);
      dqs_tin     <= dqs_t(state);
      busy        <= (state != ST_IDLE);
      dci_disable <= !window_open || (state != ST_IDLE);
    end
  end

`ifdef DQS_WR_ERR_EN
  logic err_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (err_set) err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
      err <= err_flag;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_set ^ err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dqs_wr_pattern_gen.sv
// Bench for dqs_wr_pattern_gen: timeline model of expected
// nibble patterns, directed scenarios plus random traffic.
module tb_dqs_wr_pattern_gen;

  localparam int RDW = 4;
  localparam int N = 4096;
`ifdef DQS_WR_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_req = 1'b0;
  logic rd_req = 1'b0;
  logic err_clr = 1'b0;
  logic [3:0] dqs_din, dqs_tin;
  logic dci_disable, busy, err;

  dqs_wr_pattern_gen #(
    .RD_WINDOW(RDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .err_clr    (err_clr),
    .dqs_din    (dqs_din),
    .dqs_tin    (dqs_tin),
    .dci_disable(dci_disable),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int last_edge = 0;

  // lab[k]: burst phase visible after edge k
  // 0 idle, 1 pre, 2 b0, 3 b1, 4 post
  int lab[N];
  bit exp_err[N];
  bit exp_dci[N];
  int win_end = -100;
  bit eflag = 1'b0;

  logic [3:0] din_log[N], tin_log[N];
  logic dci_log[N], busy_log[N], err_log[N];

  function automatic logic [3:0] pdin(int l);
    return (l == 2 || l == 3) ? 4'h5 : 4'h0;
  endfunction

  function automatic logic [3:0] ptin(int l);
    case (l)
      1: return 4'h3;
      2, 3: return 4'h0;
      4: return 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      din_log[cyc] = dqs_din;
      tin_log[cyc] = dqs_tin;
      dci_log[cyc] = dci_disable;
      busy_log[cyc] = busy;
      err_log[cyc] = err;
      check("din", dqs_din, pdin(lab[cyc]));
      check("tin", dqs_tin, ptin(lab[cyc]));
      check("dci", {3'b0, dci_disable}, {3'b0, exp_dci[cyc]});
      check("busy", {3'b0, busy}, {3'b0, lab[cyc] != 0});
      check("err", {3'b0, err}, {3'b0, exp_err[cyc]});
    end
  end

  // Inputs sampled at edge n; outputs for edge n decided here.
  task automatic model_edge(int n, bit w, bit r, bit c);
    bit wok, rok, set;
    exp_dci[n] = (lab[n] != 0) || (n > win_end);
    wok = w && (n > win_end) &&
          (lab[n] == 0 || lab[n] == 3 || lab[n] == 4);
    if (wok) begin
      if (lab[n] == 3) begin
        lab[n+1] = 2; lab[n+2] = 3; lab[n+3] = 4;
      end else begin
        lab[n+1] = 1; lab[n+2] = 2;
        lab[n+3] = 3; lab[n+4] = 4;
      end
    end
    rok = r && lab[n-1] == 0 && lab[n] == 0 && !wok;
    if (rok) win_end = n + RDW;
    set = (w && !wok) || (r && !rok);
    if (ERR_ON) eflag = set ? 1'b1 : (c ? 1'b0 : eflag);
    exp_err[n+1] = eflag;
  endtask

  task automatic step(bit w, bit r, bit c);
    @(negedge clk);
    #1;
    wr_req = w;
    rd_req = r;
    err_clr = c;
    last_edge = cyc + 1;
    model_edge(last_edge, w, r, c);
  endtask

  task automatic run_to(int e);
    while (last_edge + 1 < e) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    err_clr = 1'b0;
    #1;
    check("rst_din", dqs_din, 4'h0);
    check("rst_tin", dqs_tin, 4'hF);
    check("rst_dci", {3'b0, dci_disable}, 4'h1);
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_err", {3'b0, err}, 4'h0);
    for (int j = cyc + 1; j < N; j++) begin
      lab[j] = 0;
      exp_err[j] = 1'b0;
    end
    win_end = -100;
    eflag = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    last_edge = cyc + 1;
    model_edge(last_edge, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < N; j++) begin
      lab[j] = 0;
      exp_err[j] = 1'b0;
      exp_dci[j] = 1'b1;
    end
    do_reset();

    // single write, then read window with extension
    run_to(10); step(1'b1, 1'b0, 1'b0);
    run_to(20); step(1'b0, 1'b1, 1'b0);
    run_to(23); step(1'b0, 1'b1, 1'b0);
    // seamless pair
    run_to(40); step(1'b1, 1'b0, 1'b0);
    run_to(43); step(1'b1, 1'b0, 1'b0);
    // second request lands in B0
    run_to(60); step(1'b1, 1'b0, 1'b0);
    run_to(62); step(1'b1, 1'b0, 1'b0);
    run_to(70); step(1'b0, 1'b0, 1'b1);
    // read during a write
    run_to(80); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_to(90); step(1'b0, 1'b0, 1'b1);
    // reset while B0 is on the pins
    run_to(100); step(1'b1, 1'b0, 1'b0);
    run_to(103);
    @(negedge clk);
    #1;
    check("pre_rst_tin", dqs_tin, 4'h0);
    do_reset();
    run_to(110); step(1'b1, 1'b0, 1'b0);
    run_to(118);

    check("w_tin11", tin_log[11], 4'h3);
    check("w_tin12", tin_log[12], 4'h0);
    check("w_tin13", tin_log[13], 4'h0);
    check("w_tin14", tin_log[14], 4'hC);
    check("w_tin15", tin_log[15], 4'hF);
    check("w_din11", din_log[11], 4'h0);
    check("w_din12", din_log[12], 4'h5);
    check("w_din13", din_log[13], 4'h5);
    check("w_din14", din_log[14], 4'h0);
    check("w_busy10", {3'b0, busy_log[10]}, 4'h0);
    check("w_busy11", {3'b0, busy_log[11]}, 4'h1);
    check("w_busy14", {3'b0, busy_log[14]}, 4'h1);
    check("w_busy15", {3'b0, busy_log[15]}, 4'h0);
    check("r_dci20", {3'b0, dci_log[20]}, 4'h1);
    check("r_dci21", {3'b0, dci_log[21]}, 4'h0);
    check("r_dci24", {3'b0, dci_log[24]}, 4'h0);
    check("r_dci27", {3'b0, dci_log[27]}, 4'h0);
    check("r_dci28", {3'b0, dci_log[28]}, 4'h1);
    check("s_tin41", tin_log[41], 4'h3);
    check("s_tin44", tin_log[44], 4'h0);
    check("s_din45", din_log[45], 4'h5);
    check("s_tin46", tin_log[46], 4'hC);
    check("s_tin47", tin_log[47], 4'hF);
    check("s_err47", {3'b0, err_log[47]}, 4'h0);
    check("i_tin64", tin_log[64], 4'hC);
    check("i_tin66", tin_log[66], 4'hF);
    check("i_err62", {3'b0, err_log[62]}, 4'h0);
    check("i_err63", {3'b0, err_log[63]}, {3'b0, ERR_ON});
    check("i_err69", {3'b0, err_log[69]}, {3'b0, ERR_ON});
    check("i_err71", {3'b0, err_log[71]}, 4'h0);
    check("c_dci83", {3'b0, dci_log[83]}, 4'h1);
    check("c_dci86", {3'b0, dci_log[86]}, 4'h1);
    check("c_err82", {3'b0, err_log[82]}, {3'b0, ERR_ON});
    check("c_err91", {3'b0, err_log[91]}, 4'h0);
    check("x_tin111", tin_log[111], 4'h3);
    check("x_din112", din_log[112], 4'h5);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #1;
        do_reset();
      end else begin
        step($urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 11) == 0);
      end
    end
    repeat (8) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dqs_wr_pattern_gen.md
# dqs_wr_pattern_gen

Generates the per-cycle 4-bit DQS data and tristate nibbles, plus DCI-termination control, for one DDR3 byte lane. It sits directly upstream of the DQS single-bit I/O: its `dqs_din`/`dqs_tin`/`dci_disable` drive that block's `din`/`tin`/`dci_disable`. It turns write-burst and read-window requests from the command sequencer into preamble, toggle and postamble patterns, with support for seamless back-to-back BL8 writes.

## Interface
Parameters:
- `RD_WINDOW`, 4: number of `clk` cycles DCI termination stays enabled after a read request (1..15).

Ports:
- `clk` in 1: parallel (clk_div-rate) clock; each cycle carries 4 serial bits, 2 tCK.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_req` in 1: single-cycle pulse; requests one BL8 write burst.
- `rd_req` in 1: single-cycle pulse; opens or extends the read termination window.
- `err_clr` in 1: clears `err` (only with DQS_WR_ERR_EN).
- `dqs_din` out 4: DQS serial data; bit 0 is transmitted first.
- `dqs_tin` out 4: DQS tristate per bit; 1 = high-Z.
- `dci_disable` out 1: 1 disables DCI termination; 0 only inside a read window.
- `busy` out 1: 1 while the write FSM is not IDLE.
- `err` out 1: sticky flag for illegal requests.

## Operation
- Write FSM states: IDLE, PRE, B0, B1, POST. All outputs are registered.
- Per-state outputs (`dqs_din` / `dqs_tin`):
  - IDLE: 4'b0000 / 4'b1111.
  - PRE: 4'b0000 / 4'b0011. Bits 0–1 are high-Z; bits 2–3 drive low, giving a 1 tCK preamble.
  - B0 and B1: 4'b0101 / 4'b0000. Bit 0 is high, so there are 4 DQS rising edges per state pair.
  - POST: 4'b0000 / 4'b1100. Drives low for 1 tCK, then releases.
- Transitions:
  - IDLE→PRE on `wr_req`.
  - PRE→B0, then B0→B1.
  - B1→B0 on `wr_req` (seamless burst); otherwise B1→POST.
  - POST→PRE on `wr_req`; otherwise POST→IDLE.
- Illegal `wr_req`: arriving in PRE or B0, or while the read window is open. The request is ignored and `err` is set.
- Read window: a 4-bit down-counter.
  - `rd_req` loads the counter with RD_WINDOW. `dci_disable` is 0 while the counter is nonzero; the counter decrements each cycle.
  - `rd_req` while the window is open reloads the counter (extends the window).
  - `rd_req` while `busy` is high is ignored and sets `err`.
- Simultaneous legal `wr_req` and `rd_req` in IDLE: the write wins, the read is ignored, and `err` is set.
- `dci_disable` is forced to 1 whenever `busy` is high.
- `err` is sticky until `err_clr`. If `err_clr` and a new error occur in the same cycle, the set wins.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous). The pattern is truncated with no postamble; the sequencer is responsible for re-issuing the request.

## Timing
- Reset values: `dqs_din`=4'h0, `dqs_tin`=4'hF, `dci_disable`=1, `busy`=0, `err`=0, FSM=IDLE, counter=0.
- A `wr_req` sampled at edge N produces:
  - PRE outputs after edge N+1;
  - B0 at N+2 and B1 at N+3;
  - POST at N+4, then IDLE at N+5.
- `busy` is 1 from N+1 through N+4.
- Seamless write: `wr_req` in B1 at edge M gives B0 at M+1, with no PRE or POST between the bursts.
- Read: `rd_req` at edge N gives `dci_disable`=0 for exactly RD_WINDOW cycles, N+1..N+RD_WINDOW.
- Reads and writes have no combinational input-to-output path.

## Configuration
- `DQS_WR_ERR_EN` defined: `err`/`err_clr` logic is compiled in as described.
- Not defined: `err` is tied to 0 and `err_clr` is ignored. Illegal requests are still ignored, identically.

## Structure
- Shared PHY package holds:
  - state encodings (3-bit, IDLE=0);
  - the pattern constants `DQS_PRE_D/T`, `DQS_TOGGLE_D`, `DQS_POST_T`, `DQS_IDLE_T`;
  - `RD_WINDOW` width (4).
- One natural sub-module: `dci_window_timer`. It is the loadable, reloadable down-counter that outputs `window_open`.

## Test plan
- Single write: `wr_req` at cycle 10 → `dqs_tin` reads 3,0,0,C,F on cycles 11–15; `dqs_din` reads 0,5,5,0 on cycles 11–14; `busy` is high on cycles 11–14.
- Seamless write: `wr_req` at 10 and 13 → B0,B1,B0,B1 on cycles 12–15, POST at 16, no PRE between; `err` stays 0.
- Illegal write: `wr_req` at 10 and 12 (the second lands in B0) → only one burst; `err`=1 from 13 until `err_clr`.
- Read window, RD_WINDOW=4: `rd_req` at 20 → `dci_disable`=0 on cycles 21–24. A second `rd_req` at 23 extends the low period through cycle 27.
- Conflict: `rd_req` at 11 during a write → ignored; `dci_disable` stays 1; `err`=1. Repeat with DQS_WR_ERR_EN undefined → `err` stays 0.
- Reset during B0: assert `rst` → `dqs_tin`=F, `dqs_din`=0, `busy`=0 immediately. After release, the next `wr_req` produces a normal PRE.
